// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stalls, branch/jump redirect and flush, with perf counters.
// Redirect/stall/flush are combinational in the detecting cycle; multi-cycle holds are tracked by a small FSM.
module hazard_ctrl_unit #(
    parameter int XLEN        = 32,
    parameter int RAW         = 5,
    parameter int LOAD_LAT    = 1,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       branch,
    input  logic [2:0]       func3,
    input  logic             alu_zero,
    input  logic [XLEN-1:0]  pc_imm,
    input  logic [XLEN-1:0]  alu_out,
    input  logic             ex_mem_read,
    input  logic [RAW-1:0]   ex_rd,
    input  logic [RAW-1:0]   id_rs1,
    input  logic [RAW-1:0]   id_rs2,
    input  logic [1:0]       id_use,
    output logic             stall,
    output logic             bubble,
    output logic             flush,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  pc_redirect,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {IDLE, LSTALL, FLUSH} state_t;

    localparam logic [2:0] LSTALL_INIT = 3'(LOAD_LAT - 1);
    localparam logic [2:0] FLUSH_INIT  = 3'(FLUSH_DEPTH - 1);

    state_t           state;
    logic [2:0]       cnt;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    logic             cb_taken;
    logic             take;
    logic [XLEN-1:0]  target;
    logic             load_haz;

    always_comb begin
        cb_taken = 1'b0;
        case (func3)
            3'b000, 3'b101, 3'b111: cb_taken = alu_zero;
            3'b001, 3'b100, 3'b110: cb_taken = ~alu_zero;
            default:                cb_taken = 1'b0;
        endcase
    end

    assign take     = ((branch == 2'b01) && cb_taken) || (branch == 2'b10) || (branch == 2'b11);
    assign target   = (branch == 2'b10) ? alu_out : pc_imm;
    // x0 is hardwired zero, so a load targeting it can never create a dependency
    assign load_haz = ex_mem_read && (ex_rd != '0) &&
                      ((id_use[0] && (id_rs1 == ex_rd)) || (id_use[1] && (id_rs2 == ex_rd)));

    always_comb begin
        stall          = 1'b0;
        bubble         = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        pc_redirect    = '0;
        if (!rst) begin
            case (state)
                IDLE, LSTALL: begin
                    if (take) begin
                        redirect_valid = 1'b1;
                        pc_redirect    = target;
                        flush          = 1'b1;
                    end else if (load_haz || (state == LSTALL)) begin
                        stall  = 1'b1;
                        bubble = 1'b1;
                    end
                end
                FLUSH:   flush = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + 1'b1;
            if (flush && (flush_count != {CNT_W{1'b1}}))
                flush_count <= flush_count + 1'b1;

            case (state)
                IDLE, LSTALL: begin
                    if (take) begin
                        if (FLUSH_DEPTH > 1) begin
                            state <= FLUSH;
                            cnt   <= FLUSH_INIT;
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end else if (state == LSTALL) begin
                        if (cnt <= 3'd1) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt - 3'd1;
                        end
                    end else if (load_haz && (LOAD_LAT > 1)) begin
                        state <= LSTALL;
                        cnt   <= LSTALL_INIT;
                    end
                end
                FLUSH: begin
                    if (cnt <= 3'd1) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign stall_cnt = rst ? '0 : stall_count;
    assign flush_cnt = rst ? '0 : flush_count;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: vector table with scoreboard on one instance, hand sequences on a second.
module tb_hazard_ctrl_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A: LOAD_LAT=3, FLUSH_DEPTH=2, CNT_W=16
    logic        rst;
    logic [1:0]  branch;
    logic [2:0]  func3;
    logic        alu_zero;
    logic [31:0] pc_imm, alu_out;
    logic        ex_mem_read;
    logic [4:0]  ex_rd, id_rs1, id_rs2;
    logic [1:0]  id_use;
    logic        stall, bubble, flush, redirect_valid;
    logic [31:0] pc_redirect;
    logic [15:0] stall_cnt, flush_cnt;

    hazard_ctrl_unit #(.XLEN(32), .RAW(5), .LOAD_LAT(3), .FLUSH_DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .branch(branch), .func3(func3), .alu_zero(alu_zero),
        .pc_imm(pc_imm), .alu_out(alu_out), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use(id_use), .stall(stall), .bubble(bubble),
        .flush(flush), .redirect_valid(redirect_valid), .pc_redirect(pc_redirect),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

    // Instance B: LOAD_LAT=4, FLUSH_DEPTH=1, CNT_W=4
    logic        b_rst;
    logic [1:0]  b_branch;
    logic [31:0] b_pc_imm;
    logic        b_mem_read;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [1:0]  b_use;
    logic        b_stall, b_bubble, b_flush, b_rv;
    logic [31:0] b_pc;
    logic [3:0]  b_scnt, b_fcnt;

    hazard_ctrl_unit #(.XLEN(32), .RAW(5), .LOAD_LAT(4), .FLUSH_DEPTH(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst(b_rst), .branch(b_branch), .func3(3'b000), .alu_zero(1'b0),
        .pc_imm(b_pc_imm), .alu_out(32'h0), .ex_mem_read(b_mem_read), .ex_rd(b_rd),
        .id_rs1(b_rs1), .id_rs2(b_rs2), .id_use(b_use), .stall(b_stall), .bubble(b_bubble),
        .flush(b_flush), .redirect_valid(b_rv), .pc_redirect(b_pc),
        .stall_cnt(b_scnt), .flush_cnt(b_fcnt));

    typedef struct {
        logic        rst;
        logic [1:0]  br;
        logic [2:0]  f3;
        logic        az;
        logic [31:0] pci, alu;
        logic        mr;
        logic [4:0]  rd, rs1, rs2;
        logic [1:0]  idu;
        logic [3:0]  o;      // {stall, bubble, flush, redirect_valid}
        logic [31:0] pc;
        int          sc, fc;
    } vec_t;

    typedef struct {
        int          idx;
        logic [3:0]  o;
        logic [31:0] pc;
        int          sc, fc;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    task automatic add(input logic r, input logic [1:0] br, input logic [2:0] f3, input logic az,
                       input logic [31:0] pci, input logic [31:0] alu, input logic mr,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [1:0] idu, input logic [3:0] o, input logic [31:0] pc,
                       input int sc, input int fc);
        vec_t v;
        v.rst = r; v.br = br; v.f3 = f3; v.az = az; v.pci = pci; v.alu = alu; v.mr = mr;
        v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.idu = idu; v.o = o; v.pc = pc; v.sc = sc; v.fc = fc;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_b(input logic r, input logic [1:0] br, input logic [31:0] pci,
                           input logic mr, input logic [4:0] rd, input logic [4:0] rs2,
                           input logic [1:0] idu);
        @(posedge clk);
        #1;
        b_rst = r; b_branch = br; b_pc_imm = pci; b_mem_read = mr;
        b_rd = rd; b_rs1 = 5'd0; b_rs2 = rs2; b_use = idu;
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        int   nstall;

        rst = 1'b1; branch = '0; func3 = '0; alu_zero = 1'b0; pc_imm = '0; alu_out = '0;
        ex_mem_read = 1'b0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0; id_use = '0;
        b_rst = 1'b1; b_branch = '0; b_pc_imm = '0; b_mem_read = 1'b0;
        b_rd = '0; b_rs1 = '0; b_rs2 = '0; b_use = '0;

        //   rst br  f3  az pci       alu        mr rd  rs1 rs2 idu  o        pc         sc fc
        add(1, 0, 0, 0, 32'h0,   32'h0,     0, 0,  0,  0,  0, 4'b0000, 32'h0,    0, 0);
        add(1, 0, 0, 0, 32'h0,   32'h0,     1, 5,  0,  5,  2, 4'b0000, 32'h0,    0, 0);
        add(0, 0, 0, 0, 32'h0,   32'h0,     0, 0,  0,  0,  0, 4'b0000, 32'h0,    0, 0);
        add(0, 0, 0, 0, 32'h0,   32'h0,     1, 5,  0,  5,  2, 4'b1100, 32'h0,    0, 0);
        add(0, 0, 0, 0, 32'h0,   32'h0,     0, 0,  0,  0,  0, 4'b1100, 32'h0,    1, 0);
        add(0, 0, 0, 0, 32'h0,   32'h0,     0, 0,  0,  0,  0, 4'b1100, 32'h0,    2, 0);
        add(0, 0, 0, 0, 32'h0,   32'h0,     0, 0,  0,  0,  0, 4'b0000, 32'h0,    3, 0);
        add(0, 0, 0, 0, 32'h0,   32'h0,     1, 0,  0,  0,  1, 4'b0000, 32'h0,    3, 0);
        add(0, 0, 0, 0, 32'h0,   32'h0,     1, 7,  7,  0,  2, 4'b0000, 32'h0,    3, 0);
        add(0, 0, 0, 0, 32'h0,   32'h0,     0, 7,  7,  0,  1, 4'b0000, 32'h0,    3, 0);
        add(0, 1, 1, 0, 32'h100, 32'h0,     0, 0,  0,  0,  0, 4'b0011, 32'h100,  3, 0);
        add(0, 0, 0, 0, 32'h0,   32'h0,     0, 0,  0,  0,  0, 4'b0010, 32'h0,    3, 1);
        add(0, 0, 0, 0, 32'h0,   32'h0,     0, 0,  0,  0,  0, 4'b0000, 32'h0,    3, 2);
        add(0, 1, 1, 1, 32'h100, 32'h0,     0, 0,  0,  0,  0, 4'b0000, 32'h0,    3, 2);
        add(1, 0, 0, 0, 32'h0,   32'h0,     0, 0,  0,  0,  0, 4'b0000, 32'h0,    0, 0);
        add(0, 2, 0, 0, 32'h999, 32'h2004,  1, 5,  5,  0,  1, 4'b0011, 32'h2004, 0, 0);
        add(0, 3, 0, 0, 32'h40,  32'h0,     1, 5,  5,  0,  1, 4'b0010, 32'h0,    0, 1);
        add(0, 0, 0, 0, 32'h0,   32'h0,     0, 0,  0,  0,  0, 4'b0000, 32'h0,    0, 2);
        add(0, 0, 0, 0, 32'h0,   32'h0,     1, 3,  3,  9,  1, 4'b1100, 32'h0,    0, 2);
        add(0, 3, 0, 0, 32'h80,  32'h0,     0, 0,  0,  0,  0, 4'b0011, 32'h80,   1, 2);
        add(0, 0, 0, 0, 32'h0,   32'h0,     0, 0,  0,  0,  0, 4'b0010, 32'h0,    1, 3);
        add(0, 0, 0, 0, 32'h0,   32'h0,     0, 0,  0,  0,  0, 4'b0000, 32'h0,    1, 4);
        add(0, 1, 0, 1, 32'h10,  32'h0,     0, 0,  0,  0,  0, 4'b0011, 32'h10,   1, 4);
        add(0, 0, 0, 0, 32'h0,   32'h0,     0, 0,  0,  0,  0, 4'b0010, 32'h0,    1, 5);
        add(0, 1, 2, 1, 32'h10,  32'h0,     0, 0,  0,  0,  0, 4'b0000, 32'h0,    1, 6);
        add(0, 1, 3, 0, 32'h10,  32'h0,     0, 0,  0,  0,  0, 4'b0000, 32'h0,    1, 6);
        add(0, 1, 6, 1, 32'h10,  32'h0,     0, 0,  0,  0,  0, 4'b0000, 32'h0,    1, 6);
        add(0, 1, 7, 0, 32'h10,  32'h0,     0, 0,  0,  0,  0, 4'b0000, 32'h0,    1, 6);
        add(0, 1, 5, 1, 32'h20,  32'h0,     0, 0,  0,  0,  0, 4'b0011, 32'h20,   1, 6);
        add(0, 0, 0, 0, 32'h0,   32'h0,     0, 0,  0,  0,  0, 4'b0010, 32'h0,    1, 7);
        add(0, 1, 4, 0, 32'h30,  32'h0,     0, 0,  0,  0,  0, 4'b0011, 32'h30,   1, 8);
        add(0, 0, 0, 0, 32'h0,   32'h0,     0, 0,  0,  0,  0, 4'b0010, 32'h0,    1, 9);
        add(0, 0, 0, 0, 32'h0,   32'h0,     0, 0,  0,  0,  0, 4'b0000, 32'h0,    1, 10);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            rst = vecs[i].rst; branch = vecs[i].br; func3 = vecs[i].f3; alu_zero = vecs[i].az;
            pc_imm = vecs[i].pci; alu_out = vecs[i].alu; ex_mem_read = vecs[i].mr;
            ex_rd = vecs[i].rd; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; id_use = vecs[i].idu;
            e.idx = i; e.o = vecs[i].o; e.pc = vecs[i].pc; e.sc = vecs[i].sc; e.fc = vecs[i].fc;
            exp_q.push_back(e);
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("vec%0d ctl{stall,bubble,flush,rv}", e.idx),
                  int'({stall, bubble, flush, redirect_valid}), int'(e.o));
            check($sformatf("vec%0d pc_redirect", e.idx), int'(pc_redirect), int'(e.pc));
            check($sformatf("vec%0d stall_cnt", e.idx), int'(stall_cnt), e.sc);
            check($sformatf("vec%0d flush_cnt", e.idx), int'(flush_cnt), e.fc);
        end

        // Instance B: reset during the second stall cycle aborts the stall
        drive_b(1, 0, 0, 0, 0, 0, 0);
        check("b reset outputs", int'({b_stall, b_bubble, b_flush, b_rv, b_scnt}), 0);
        drive_b(0, 0, 0, 1, 5, 5, 2);
        check("b first stall", int'(b_stall), 1);
        drive_b(1, 0, 0, 0, 0, 0, 0);
        check("b stall during rst", int'(b_stall), 0);
        drive_b(0, 0, 0, 0, 0, 0, 0);
        check("b stall after rst", int'(b_stall), 0);
        check("b stall_cnt after rst", int'(b_scnt), 0);

        // Single hazard gives exactly LOAD_LAT=4 stall cycles
        nstall = 0;
        drive_b(0, 0, 0, 1, 5, 5, 2);
        nstall += int'(b_stall);
        for (int k = 0; k < 5; k++) begin
            drive_b(0, 0, 0, 0, 0, 0, 0);
            nstall += int'(b_stall);
        end
        check("b stall cycles", nstall, 4);
        check("b stall_cnt lat4", int'(b_scnt), 4);

        // Saturation of a 4-bit counter under continuous hazards
        drive_b(1, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 21; k++) begin
            drive_b(0, 0, 0, 1, 5, 5, 2);
            if (k == 15) check("b stall_cnt pre-sat", int'(b_scnt), 14);
            if (k == 16) check("b stall_cnt sat", int'(b_scnt), 15);
            if (k == 21) begin
                check("b stall_cnt held", int'(b_scnt), 15);
                check("b stall continuous", int'(b_stall), 1);
            end
        end

        // FLUSH_DEPTH=1: one flush cycle, FSM stays idle
        drive_b(1, 0, 0, 0, 0, 0, 0);
        drive_b(0, 3, 32'h44, 0, 0, 0, 0);
        check("b jal ctl", int'({b_flush, b_rv}), 3);
        check("b jal pc", int'(b_pc), 32'h44);
        drive_b(0, 0, 0, 0, 0, 0, 0);
        check("b post-flush ctl", int'({b_flush, b_rv, b_stall}), 0);
        check("b flush_cnt", int'(b_fcnt), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
